p_sink: RTL and testbench
=========================

# p_sink

Receive-side terminator for the ce-gated `p_mod` pipeline (`WIDTH`-bit data, `DEPTH` register stages, no valid of its own). `p_sink` generates the pipeline's `ce` and tags which stages hold real words. It captures each real word from the pipeline output into a FIFO and presents it to a downstream consumer over valid/ready. The pipeline stalls (`ce` low) instead of dropping data when the consumer backpressures.

## Interface

**Parameters**
- `WIDTH`, 8 — data width; must match `p_mod` `WIDTH`.
- `DEPTH`, 6 — `p_mod` latency in ce-enabled cycles; minimum 2.
- `FIFO_DEPTH`, 8 — capture FIFO entries; power of 2, minimum 2.

**Ports**
- `clk`, in, 1 — sole clock; all state updates on the rising edge.
- `rst`, in, 1 — synchronous, active-high reset.
- `src_valid`, in, 1 — source is presenting a word to `p_mod.din` this cycle.
- `ce`, out, 1 — pipeline enable, driven to `p_mod.ce`; also acts as the source's ready.
- `pipe_dout`, in, `WIDTH` — from `p_mod.dout`.
- `m_data`, out, `WIDTH` — head-of-FIFO word.
- `m_valid`, out, 1 — `m_data` is valid.
- `m_ready`, in, 1 — consumer accepts the word.
- `count`, out, `$clog2(FIFO_DEPTH)+1` — FIFO occupancy.

## Operation

- **Tag shift register `vtag[DEPTH-1:0]`**
  - On an edge with `ce`=1: `vtag <= {vtag[DEPTH-2:0], src_valid}`.
  - On an edge with `ce`=0: `vtag` holds, mirroring the frozen pipeline.
- **Capture**
  - On an edge with `ce`=1 and `vtag[DEPTH-1]`=1 (evaluated before the edge), `pipe_dout` is pushed into the FIFO.
  - Words presented while `ce`=0 are not accepted. The source must hold `src_valid` and `din` until it sees `ce`=1.
- **ce generation**
  - `ce = !rst && (count < FIFO_DEPTH)`.
  - `ce` is combinational from registered state only; there is no path from `m_ready` to `ce`.
  - A push therefore never overflows the FIFO.
- **Pop**
  - Pop occurs on an edge with `m_valid` && `m_ready`.
  - `m_valid = (count != 0)`.
  - `m_data` = FIFO head when `m_valid`=1, otherwise all-zero.
- **Simultaneous push and pop:** both occur and `count` is unchanged. When full, `ce`=0, so a pop alone frees one slot and `ce` rises the next cycle.
- **Ordering:** strict FIFO. Words emerge in `src_valid` order with no loss and no duplication.
- **Pointer arithmetic:** read/write pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally modulo `FIFO_DEPTH`. `count` carries one extra bit so full (`count`==`FIFO_DEPTH`) is distinguishable from empty.

## Timing

- **Reset values** (at the first edge with `rst`=1): `vtag`=0, pointers=0, `count`=0, `m_valid`=0, `m_data`=0. `ce`=0 while `rst` is high and 1 on the first cycle after reset.
- **Reset mid-operation:** all in-flight tags and FIFO contents are discarded. Stale `pipe_dout` values are never captured, because their tags are cleared.
- **Latency:** a word accepted at ce-edge k is pushed at ce-edge k+`DEPTH` and is visible on `m_valid`/`m_data` in the cycle after that edge.
  - With `ce` continuously high, that is `DEPTH` clocks from acceptance to `m_valid`.
  - Each `ce`=0 cycle adds one clock.
- **Throughput:** one word per clock while the consumer holds `m_ready`=1.

## Configuration

- `P_SINK_FLUSH_EN` defined:
  - Adds input port `flush` (1 bit).
  - `flush` acts synchronously: on an edge with `flush`=1, `vtag`, the pointers and `count` clear; `ce` is unaffected.
  - Any push or pop on the same edge is ignored; flush wins.
  - `m_valid`=0 the next cycle.
- `P_SINK_FLUSH_EN` undefined: no `flush` port and no flush logic.

## Structure

- **Package `p_pkg`** holds:
  - the default `WIDTH`/`DEPTH`/`FIFO_DEPTH` localparams;
  - the `count` width function;
  - typedef `p_word_t` (logic [WIDTH-1:0], default width).
- **Sub-module `p_sink_fifo`**: a synchronous FIFO (storage, pointers, count, full/empty). `p_sink` contains only `vtag`, the `ce` logic and the flush logic.

## Test plan

- **Reset:** `rst`=1 for 3 cycles → `ce`=0, `m_valid`=0, `m_data`=0, `count`=0; cycle after release → `ce`=1.
- **Single word:** (`DEPTH`=6) `src_valid`=1 with `din`=0x01 for one ce-edge, `m_ready`=1 → `m_valid`=1 with `m_data`=0x01 exactly 6 clocks later, for one cycle.
- **Backpressure:** `m_ready`=0, stream 0x10..0x19 → `count` reaches 8 and `ce`=0, pipeline frozen. Then `m_ready`=1 → output 0x10..0x19 in order, no gaps after fill, no loss.
- **Full with simultaneous pop:** FIFO full, one pop → `count`=7 and `ce`=1 the next cycle. Then steady push+pop → `count` stays 7.
- **Reset mid-stream:** assert `rst` with 3 words in flight and 2 in the FIFO → after release, `m_valid` stays 0 for 10 cycles with `src_valid`=0.
- **Flush** (`P_SINK_FLUSH_EN`): pulse `flush` with 4 words queued, `m_ready`=0 → `count`=0 and `m_valid`=0 the next cycle; a new word 0xA5 then arrives after `DEPTH` clocks.

Source files
------------

// File: rtl/p_pkg.sv
// Shared definitions for the p_sink receive terminator.
// Holds the default data/pipeline/FIFO sizes, the occupancy-width helper and the
// default-width word type. Imported by p_sink_if, p_sink_fifo and p_sink.
package p_pkg;

  localparam int unsigned DefWidth     = 8;
  localparam int unsigned DefDepth     = 6;
  localparam int unsigned DefFifoDepth = 8;

  // Occupancy needs one bit more than the pointers so full and empty differ.
  function automatic int unsigned count_width(input int unsigned fifo_depth);
    return $clog2(fifo_depth) + 1;
  endfunction

  typedef logic [DefWidth-1:0] p_word_t;

endpackage

// File: rtl/p_sink_if.sv
// Handshake bundle around p_sink.
//   src_valid : source presents a word to the pipeline input this cycle
//   ce        : pipeline enable, doubles as the source's ready
//   pipe_dout : pipeline output word
//   m_data    : head-of-FIFO word (zero when m_valid is low)
//   m_valid   : m_data holds a real word
//   m_ready   : consumer accepts m_data
//   count     : capture FIFO occupancy
// slave is the p_sink view; master is the source/pipeline/consumer view.
interface p_sink_if #(
  parameter int unsigned WIDTH      = p_pkg::DefWidth,
  parameter int unsigned FIFO_DEPTH = p_pkg::DefFifoDepth
) ();

  localparam int unsigned CntW = p_pkg::count_width(FIFO_DEPTH);

  logic             src_valid;
  logic             ce;
  logic [WIDTH-1:0] pipe_dout;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic [CntW-1:0]  count;

  modport slave (
    input  src_valid, pipe_dout, m_ready,
    output ce, m_data, m_valid, count
  );

  modport master (
    output src_valid, pipe_dout, m_ready,
    input  ce, m_data, m_valid, count
  );

endinterface

// File: rtl/p_sink_fifo.sv
// Synchronous capture FIFO for p_sink.
//   clk, rst : clock and synchronous active-high reset
//   clr      : synchronous clear of pointers and occupancy (wins over push/pop)
//   push     : write wdata this edge (ignored when full)
//   wdata    : word to write
//   pop      : drop the head word this edge (ignored when empty)
//   rdata    : head word, all-zero when empty
//   count    : occupancy, FIFO_DEPTH means full
//   full     : count == FIFO_DEPTH
//   empty    : count == 0
// FIFO_DEPTH must be a power of two so the pointers wrap naturally.
module p_sink_fifo
  import p_pkg::*;
#(
  parameter int unsigned WIDTH      = DefWidth,
  parameter int unsigned FIFO_DEPTH = DefFifoDepth
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  clr,
  input  logic                                  push,
  input  logic [WIDTH-1:0]                      wdata,
  input  logic                                  pop,
  output logic [WIDTH-1:0]                      rdata,
  output logic [count_width(FIFO_DEPTH)-1:0]    count,
  output logic                                  full,
  output logic                                  empty
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = count_width(FIFO_DEPTH);

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  always_comb begin
    full     = (count_q == CntW'(FIFO_DEPTH));
    empty    = (count_q == '0);
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + CntW'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is read until the pointers say it was written.
  always_ff @(posedge clk) begin
    if (push_ok && !clr && !rst) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_comb begin
    rdata = empty ? '0 : mem_q[rd_ptr_q];
    count = count_q;
  end

endmodule

// File: rtl/p_sink.sv
// Receive-side terminator for the ce-gated p_mod pipeline.
// Generates the pipeline enable, tracks which pipeline stages hold real words
// (vtag), captures tagged words from the pipeline output into a FIFO and
// presents them to a valid/ready consumer. When the FIFO is full the pipeline
// is stalled rather than dropping data.
//   clk, rst : clock and synchronous active-high reset
//   flush    : (P_SINK_FLUSH_EN only) synchronous clear of tags and FIFO
//   bus      : p_sink_if.slave handshake bundle (src_valid, ce, pipe_dout,
//              m_data, m_valid, m_ready, count)
// Optional feature macro: P_SINK_FLUSH_EN.
// DEPTH must be at least 2; FIFO_DEPTH a power of two, at least 2.
module p_sink
  import p_pkg::*;
#(
  parameter int unsigned WIDTH      = DefWidth,
  parameter int unsigned DEPTH      = DefDepth,
  parameter int unsigned FIFO_DEPTH = DefFifoDepth
) (
  input  logic    clk,
  input  logic    rst,
`ifdef P_SINK_FLUSH_EN
  input  logic    flush,
`endif
  p_sink_if.slave bus
);

  localparam int unsigned CntW = count_width(FIFO_DEPTH);

  logic [DEPTH-1:0] vtag_q;
  logic             clr;
  logic             ce;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [WIDTH-1:0] rdata;
  logic [CntW-1:0]  count;

`ifdef P_SINK_FLUSH_EN
  assign clr = flush;
`else
  assign clr = 1'b0;
`endif

  // ce depends only on registered occupancy, never on m_ready, so a push can
  // never land in a full FIFO.
  always_comb begin
    ce   = !rst && !full;
    push = ce && vtag_q[DEPTH-1];
    pop  = !empty && bus.m_ready;
  end

  // Tags move in lock-step with the pipeline stages; frozen while ce is low.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      vtag_q <= '0;
    end else if (ce) begin
      vtag_q <= {vtag_q[DEPTH-2:0], bus.src_valid};
    end
  end

  p_sink_fifo #(
    .WIDTH      (WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (push),
    .wdata (bus.pipe_dout),
    .pop   (pop),
    .rdata (rdata),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    bus.ce      = ce;
    bus.m_valid = !empty;
    bus.m_data  = rdata;
    bus.count   = count;
  end

endmodule

// File: tb/tb_p_sink.sv
module tb_p_sink;
  import p_pkg::*;

  localparam int unsigned WIDTH      = 8;
  localparam int unsigned DEPTH      = 6;
  localparam int unsigned FIFO_DEPTH = 8;

  typedef struct {
    logic       rst;
    logic       sv;
    p_word_t    din;
    logic       mr;
    logic       ce;
    logic       mv;
    p_word_t    md;
    logic [3:0] cnt;
  } vec_t;

  logic    clk = 1'b0;
  logic    rst;
  p_word_t din;
  p_word_t pipe [DEPTH];
`ifdef P_SINK_FLUSH_EN
  logic    flush;
`endif

  int      checks;
  int      failures;
  int      src_idx;
  int      src_len;
  p_word_t src_base;

  logic       ce_s;
  logic       mv_s;
  p_word_t    md_s;
  logic [3:0] cnt_s;

  vec_t vecs[$];

  p_sink_if #(.WIDTH(WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

  p_sink #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk   (clk),
`ifdef P_SINK_FLUSH_EN
    .flush (flush),
`endif
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural p_mod: ce-gated shift register, no reset, no valid.
  always @(posedge clk) begin
    if (bus.ce) begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign bus.pipe_dout = pipe[DEPTH-1];

  function automatic vec_t mk(logic r, logic sv, p_word_t d, logic mr,
                              logic ce, logic mv, p_word_t md, logic [3:0] cnt);
    vec_t v;
    v.rst = r;  v.sv = sv; v.din = d;  v.mr  = mr;
    v.ce  = ce; v.mv = mv; v.md  = md; v.cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_src();
    bus.src_valid = (src_idx < src_len);
    din = src_base + p_word_t'(src_idx);
  endtask

  task automatic sample();
    @(negedge clk);
    ce_s  = bus.ce;
    mv_s  = bus.m_valid;
    md_s  = bus.m_data;
    cnt_s = bus.count;
  endtask

  task automatic edge_adv();
    @(posedge clk);
    #1;
    if (ce_s && bus.src_valid) src_idx++;
  endtask

  initial begin
    int  popped;
    bit  found;

    checks = 0;
    failures = 0;
    rst = 1'b1;
    din = '0;
    bus.src_valid = 1'b0;
    bus.m_ready = 1'b0;
`ifdef P_SINK_FLUSH_EN
    flush = 1'b0;
`endif
    src_idx = 0;
    src_len = 0;
    src_base = '0;

    // rst, sv, din, mr | ce, mv, md, cnt  (expected values before the cycle's edge)
    vecs.push_back(mk(1, 0, 8'h00, 1, 0, 0, 8'h00, 0));
    vecs.push_back(mk(1, 0, 8'h00, 1, 0, 0, 8'h00, 0));
    vecs.push_back(mk(0, 1, 8'h01, 1, 1, 0, 8'h00, 0));
    for (int i = 0; i < 6; i++) vecs.push_back(mk(0, 0, 8'h00, 1, 1, 0, 8'h00, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 1, 1, 8'h01, 1));
    vecs.push_back(mk(0, 1, 8'h22, 0, 1, 0, 8'h00, 0));
    vecs.push_back(mk(0, 1, 8'h33, 0, 1, 0, 8'h00, 0));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 8'h00, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 1, 8'h22, 1));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 1, 8'h22, 2));
    vecs.push_back(mk(0, 0, 8'h00, 1, 1, 1, 8'h22, 2));
    vecs.push_back(mk(0, 0, 8'h00, 1, 1, 1, 8'h33, 1));
    vecs.push_back(mk(0, 0, 8'h00, 1, 1, 0, 8'h00, 0));

    // First reset edge, then the table (two more reset cycles, single word, pair).
    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      rst           = vecs[i].rst;
      bus.src_valid = vecs[i].sv;
      din           = vecs[i].din;
      bus.m_ready   = vecs[i].mr;
      sample();
      check($sformatf("v%0d_ce", i),    ce_s,  vecs[i].ce);
      check($sformatf("v%0d_mv", i),    mv_s,  vecs[i].mv);
      check($sformatf("v%0d_mdata", i), md_s,  vecs[i].md);
      check($sformatf("v%0d_count", i), cnt_s, vecs[i].cnt);
      edge_adv();
    end

    // Backpressure: 16 words, consumer stalled. 8 fill the FIFO, 6 sit frozen in the pipe.
    src_idx = 0; src_len = 16; src_base = 8'h10;
    bus.m_ready = 1'b0;
    for (int c = 0; c < 30; c++) begin
      drive_src(); sample(); edge_adv();
    end
    drive_src(); sample();
    check("bp_count", cnt_s, 8);
    check("bp_ce", ce_s, 0);
    check("bp_head", md_s, 8'h10);
    check("bp_accepted", src_idx, 14);
    for (int c = 0; c < 3; c++) begin
      edge_adv(); drive_src(); sample();
    end
    check("bp_frozen_accepted", src_idx, 14);
    check("bp_frozen_count", cnt_s, 8);
    edge_adv();

    // Drain with m_ready held: first pop frees a slot, then steady push+pop at count 7.
    bus.m_ready = 1'b1;
    popped = 0;
    for (int c = 0; c < 24; c++) begin
      drive_src(); sample();
      if (c < 16) check($sformatf("drain_valid_%0d", c), mv_s, 1);
      if (c >= 1 && c <= 8) begin
        check($sformatf("steady_count_%0d", c), cnt_s, 7);
        check($sformatf("steady_ce_%0d", c), ce_s, 1);
      end
      if (mv_s) begin
        check($sformatf("drain_data_%0d", popped), md_s, 8'h10 + p_word_t'(popped));
        popped++;
      end
      edge_adv();
    end
    check("drain_total", popped, 16);
    drive_src(); sample();
    check("drain_empty", mv_s, 0);
    edge_adv();

    // Reset with 2 words captured and 3 still in the pipe.
    src_idx = 0; src_len = 5; src_base = 8'h40;
    bus.m_ready = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      drive_src(); sample();
      if (cnt_s == 2) found = 1'b1;
      else edge_adv();
    end
    check("mid_reached_two", found, 1);
    check("mid_inflight", src_idx, 5);
    src_len = src_idx;
    bus.src_valid = 1'b0;
    rst = 1'b1;
    edge_adv();
    sample();
    check("mid_rst_ce", ce_s, 0);
    edge_adv();
    rst = 1'b0;
    bus.m_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      drive_src(); sample();
      check($sformatf("mid_after_valid_%0d", c), mv_s, 0);
      if (c == 0) check("mid_after_count", cnt_s, 0);
      edge_adv();
    end

`ifdef P_SINK_FLUSH_EN
    // Flush with 4 words queued, then one fresh word through the full latency.
    src_idx = 0; src_len = 4; src_base = 8'h50;
    bus.m_ready = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      drive_src(); sample();
      if (cnt_s == 4) found = 1'b1;
      else edge_adv();
    end
    check("flush_reached_four", found, 1);
    src_len = src_idx;
    flush = 1'b1;
    edge_adv();
    flush = 1'b0;
    drive_src(); sample();
    check("flush_count", cnt_s, 0);
    check("flush_valid", mv_s, 0);
    check("flush_ce", ce_s, 1);
    edge_adv();
    src_idx = 0; src_len = 1; src_base = 8'hA5;
    drive_src(); sample(); edge_adv();
    check("flush_a5_accepted", src_idx, 1);
    for (int k = 1; k <= DEPTH + 1; k++) begin
      drive_src(); sample();
      check($sformatf("flush_a5_valid_%0d", k), mv_s, (k <= DEPTH) ? 1'b0 : 1'b1);
      if (k == DEPTH + 1) check("flush_a5_data", md_s, 8'hA5);
      edge_adv();
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
